// File: rtl/mic_capture_ctrl.sv
// rtl/mic_capture_ctrl.sv - I2S mic sequencer: warm-up discard, frame packing, show-ahead FIFO
module mic_capture_ctrl #(
  parameter int DATA_W         = 16,
  parameter int FRAME_LEN      = 256,
  parameter int WARMUP_SAMPLES = 64,
  parameter int FIFO_DEPTH     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  output logic              mic_en,
  input  logic [DATA_W-1:0] in_sample,
  input  logic              in_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic [1:0]        state,
  output logic [7:0]        overflow_cnt
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WARMUP  = 2'd1,
    S_CAPTURE = 2'd2,
    S_DRAIN   = 2'd3
  } state_t;

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int IW = $clog2(FRAME_LEN);
  localparam int WW = (WARMUP_SAMPLES > 1) ? $clog2(WARMUP_SAMPLES) : 1;

  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
  localparam logic [IW-1:0] IDX_LAST  = IW'(FRAME_LEN - 1);
  localparam logic [WW-1:0] WARM_LAST = WW'((WARMUP_SAMPLES > 0) ? WARMUP_SAMPLES - 1 : 0);
  // With no warm-up configured, a start goes straight to capture.
  localparam state_t START_STATE = (WARMUP_SAMPLES == 0) ? S_CAPTURE : S_WARMUP;

  state_t          state_q, state_d;
  logic [WW-1:0]   warm_q, warm_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            stop_pend_q, stop_pend_d;
  logic [7:0]      ovf_q, ovf_d;
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   cnt_q;
  logic [DATA_W-1:0] data_mem_q [FIFO_DEPTH];
  logic            last_mem_q [FIFO_DEPTH];

  logic pop, push, is_last, stop_eff;

  assign pop      = (cnt_q != '0) && out_ready;
  assign is_last  = (idx_q == IDX_LAST);
  // A full FIFO still accepts a sample when the head leaves on the same edge.
  assign push     = (state_q == S_CAPTURE) && in_valid && ((cnt_q != DEPTH_C) || pop);
  assign stop_eff = stop || stop_pend_q;

  // Sequencer next-state: warm-up counting, frame index, stop handling, drop counting.
  always_comb begin
    state_d     = state_q;
    warm_d      = warm_q;
    idx_d       = idx_q;
    stop_pend_d = 1'b0;
    ovf_d       = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (start && !stop) begin
          state_d = START_STATE;
          ovf_d   = '0;
          idx_d   = '0;
          warm_d  = '0;
        end
      end
      S_WARMUP: begin
        if (stop) begin
          state_d = S_IDLE;
          warm_d  = '0;
        end else if (in_valid) begin
          if (warm_q == WARM_LAST) begin
            state_d = S_CAPTURE;
            warm_d  = '0;
          end else begin
            warm_d = warm_q + 1'b1;
          end
        end
      end
      S_CAPTURE: begin
        if (push) begin
          idx_d = is_last ? '0 : idx_q + 1'b1;
        end else if (in_valid && (ovf_q != 8'hFF)) begin
          ovf_d = ovf_q + 1'b1;
        end
        // Only leave on a frame boundary so every frame stays complete.
        if (stop_eff && ((push && is_last) || (!push && (idx_q == '0)))) begin
          state_d = S_DRAIN;
        end else begin
          stop_pend_d = stop_eff;
        end
      end
      S_DRAIN: begin
        if ((cnt_q == '0) || ((cnt_q == CW'(1)) && pop)) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Sequencer state registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      warm_q      <= '0;
      idx_q       <= '0;
      stop_pend_q <= 1'b0;
      ovf_q       <= '0;
    end else begin
      state_q     <= state_d;
      warm_q      <= warm_d;
      idx_q       <= idx_d;
      stop_pend_q <= stop_pend_d;
      ovf_q       <= ovf_d;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // FIFO storage; contents are don't-care until written since outputs are gated by occupancy.
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem_q[wr_ptr_q] <= in_sample;
      last_mem_q[wr_ptr_q] <= is_last;
    end
  end

  assign out_valid    = (cnt_q != '0);
  assign out_data     = out_valid ? data_mem_q[rd_ptr_q] : '0;
  assign out_last     = out_valid ? last_mem_q[rd_ptr_q] : 1'b0;
  assign state        = state_q;
  assign busy         = (state_q != S_IDLE);
  assign mic_en       = (state_q == S_WARMUP) || (state_q == S_CAPTURE);
  assign overflow_cnt = ovf_q;

endmodule

// File: tb/tb_mic_capture_ctrl.sv
// tb/tb_mic_capture_ctrl.sv - randomized scoreboard bench for mic_capture_ctrl
module tb_mic_capture_ctrl;

  localparam int DW = 16;
  localparam int FL = 8;
  localparam int WS = 4;
  localparam int FD = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          mic_en;
  logic [DW-1:0] in_sample = '0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          busy;
  logic [1:0]    state;
  logic [7:0]    overflow_cnt;

  mic_capture_ctrl #(
    .DATA_W(DW), .FRAME_LEN(FL), .WARMUP_SAMPLES(WS), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .mic_en(mic_en),
    .in_sample(in_sample), .in_valid(in_valid), .out_data(out_data),
    .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .state(state), .overflow_cnt(overflow_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: mode 0 idle, 1 warm-up, 2 capture, 3 drain.
  int m_state, m_warm, m_idx, m_occ, m_ovf;
  bit m_sp;
  logic [DW:0] sb[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_warm = 0; m_idx = 0; m_occ = 0; m_ovf = 0; m_sp = 0;
    sb.delete();
  endtask

  task automatic model_edge(input bit s, input bit t, input bit v, input logic [DW-1:0] d, input bit r);
    bit pop, pushed, was_last, stopnow;
    pop = (m_occ > 0) && r;
    pushed = 0;
    case (m_state)
      0: if (s && !t) begin
        m_state = (WS == 0) ? 2 : 1;
        m_ovf = 0; m_idx = 0; m_warm = 0;
      end
      1: if (t) begin
        m_state = 0; m_warm = 0;
      end else if (v) begin
        m_warm++;
        if (m_warm == WS) begin m_state = 2; m_warm = 0; end
      end
      2: begin
        stopnow = t || m_sp;
        was_last = (m_idx == FL - 1);
        if (v) begin
          if (m_occ < FD || pop) begin
            sb.push_back({was_last, d});
            pushed = 1;
            m_idx = (m_idx + 1) % FL;
          end else if (m_ovf < 255) begin
            m_ovf++;
          end
        end
        if (stopnow && ((pushed && was_last) || (!pushed && m_idx == 0))) begin
          m_state = 3; m_sp = 0;
        end else begin
          m_sp = stopnow;
        end
      end
      default: if (m_occ - int'(pop) == 0) m_state = 0;
    endcase
    if (m_state != 2) m_sp = 0;
    m_occ = m_occ + int'(pushed) - int'(pop);
  endtask

  task automatic check_outputs();
    chk("state", state, m_state);
    chk("mic_en", mic_en, int'(m_state == 1 || m_state == 2));
    chk("busy", busy, int'(m_state != 0));
    chk("out_valid", out_valid, int'(m_occ > 0));
    chk("overflow_cnt", overflow_cnt, m_ovf);
  endtask

  // One clock: drive inputs, advance the model, then compare after the edge.
  task automatic step(input bit s, input bit t, input bit v, input logic [DW-1:0] d, input bit r);
    start = s; stop = t; in_valid = v; in_sample = d; out_ready = r;
    model_edge(s, t, v, d, r);
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start = 0; stop = 0; in_valid = 0; out_ready = 0;
    @(posedge clk);
    #1;
    model_reset();
    check_outputs();
    chk("out_data_rst", out_data, 0);
    chk("out_last_rst", out_last, 0);
    rst_n = 1'b1;
  endtask

  task automatic warm_up();
    step(1, 0, 0, 0, 1);
    for (int i = 0; i < WS; i++) step(0, 0, 1, DW'(16'hAA00 + i), 0);
  endtask

  task automatic finish_to_idle();
    int n;
    n = 0;
    step(0, 1, 0, 0, 1);
    while (m_state != 0 && n < 80) begin
      step(0, 0, 1'($urandom % 2), DW'($urandom), 1);
      n++;
    end
    chk("reached_idle_bound", int'(n < 80), 1);
  endtask

  // Monitor: every accepted head must match the oldest expected sample.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got data %0d with no expected sample", out_data);
      end else begin
        logic [DW:0] e;
        e = sb.pop_front();
        chk("out_data", out_data, e[DW-1:0]);
        chk("out_last", out_last, e[DW]);
      end
    end
  end

  initial begin
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    // Warm-up discard: values 1..12, expect 5..12 with last on 12.
    step(1, 0, 0, 0, 1);
    for (int i = 1; i <= 12; i++) begin
      step(0, 0, 1, DW'(i), 1);
      if (i % 5 == 0) step(0, 0, 0, 0, 1);
    end
    step(0, 1, 0, 0, 1);
    chk("drain_after_boundary_stop", state, 3);
    finish_to_idle();

    // Back-pressure: 7 samples into a 4-deep FIFO, 3 dropped.
    warm_up();
    for (int i = 0; i < 7; i++) step(0, 0, 1, DW'(100 + i), 0);
    chk("ovf_after_backpressure", overflow_cnt, 3);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1);
    step(0, 0, 1, DW'(200), 1);
    finish_to_idle();

    // Full FIFO with simultaneous pop: push accepted, no drop.
    warm_up();
    for (int i = 0; i < 4; i++) step(0, 0, 1, DW'(300 + i), 0);
    step(0, 0, 1, DW'(304), 1);
    chk("ovf_full_with_pop", overflow_cnt, 0);
    finish_to_idle();

    // Conflicts: start&&stop in IDLE, stop in WARMUP.
    step(1, 1, 0, 0, 1);
    chk("idle_start_stop", state, 0);
    step(1, 0, 0, 0, 1);
    step(0, 1, 1, 0, 1);
    chk("warmup_stop_mic_en", mic_en, 0);

    // Mid-frame stop after index 3.
    warm_up();
    for (int i = 0; i < 4; i++) step(0, 0, 1, DW'(400 + i), 1);
    step(0, 1, 0, 0, 1);
    chk("stop_pending_still_capture", state, 2);
    for (int i = 4; i < 8; i++) step(0, 0, 1, DW'(400 + i), 1);
    chk("mid_frame_stop_drain", state, 3);
    finish_to_idle();

    // Randomized traffic with varying downstream readiness.
    for (int blk = 0; blk < 8; blk++) begin
      int rp;
      rp = $urandom_range(1, 4);
      for (int c = 0; c < 100; c++) begin
        step(1'($urandom % 25 == 0), 1'($urandom % 40 == 0), 1'($urandom % 2),
             DW'($urandom), 1'(($urandom % 4) < rp));
      end
    end
    finish_to_idle();

    // Reset mid-capture with a non-empty FIFO, then restart.
    warm_up();
    for (int i = 0; i < 3; i++) step(0, 0, 1, DW'(500 + i), 0);
    do_reset();
    step(1, 0, 0, 0, 1);
    chk("restart_warmup", state, 1);
    finish_to_idle();

    chk("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
